// File: rtl/group_accumulator.sv
// group_accumulator
//   Consumes grouped words of GROUP_SIZE two's-complement lanes and adds each
//   lane into its own accumulator. After num_reads_per_iter accepted words it
//   emits one sum vector. This repeats for num_iters iterations, and then the
//   block raises done. A configure pulse in any state latches new parameters
//   and restarts the run. A parameter value of 0 is treated as 1.
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   configure                latch num_iters / num_reads_per_iter and (re)start
//   num_iters                iterations to run
//   num_reads_per_iter       grouped words summed per iteration
//   data_in, valid_in        grouped input word; lane k = data_in[k*DATA_WIDTH +: DATA_WIDTH]
//   avail_out                block accepts data_in this cycle (registered)
//   data_out, valid_out      sum vector; lane k = data_out[k*ACC_WIDTH +: ACC_WIDTH]
//   avail_in                 downstream accepts data_out
//   done                     all iterations emitted
module group_accumulator #(
    parameter int DATA_WIDTH             = 16,
    parameter int GROUP_SIZE             = 4,
    parameter int ACC_WIDTH              = 32,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_in,
    input  logic                             valid_in,
    output logic                             avail_out,
    output logic [GROUP_SIZE*ACC_WIDTH-1:0]   data_out,
    output logic                             valid_out,
    input  logic                             avail_in,
    output logic                             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                              state_r;
    logic [LOG_MAX_ITERS-1:0]            iters_r;
    logic [LOG_MAX_READS_PER_ITER-1:0]   reads_r;
    logic [LOG_MAX_ITERS-1:0]            iter_cnt_r;
    logic [LOG_MAX_READS_PER_ITER-1:0]   read_cnt_r;
    logic [ACC_WIDTH-1:0]                acc_r [GROUP_SIZE];

    logic                                accept_s;
    logic                                last_read_s;
    logic                                last_iter_s;
    logic [ACC_WIDTH-1:0]                sum_s [GROUP_SIZE];
    logic [LOG_MAX_ITERS-1:0]            iters_cfg_s;
    logic [LOG_MAX_READS_PER_ITER-1:0]   reads_cfg_s;

    // Sign-extend one input lane to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
        return ACC_WIDTH'($signed(v));
    endfunction

    // Handshake decode, per-lane running sums and zero-as-one parameter mapping.
    always_comb begin
        accept_s    = valid_in & avail_out;
        last_read_s = (read_cnt_r == (reads_r - LOG_MAX_READS_PER_ITER'(1)));
        last_iter_s = (iter_cnt_r == (iters_r - LOG_MAX_ITERS'(1)));
        if (num_iters == '0) begin
            iters_cfg_s = LOG_MAX_ITERS'(1);
        end else begin
            iters_cfg_s = num_iters;
        end
        if (num_reads_per_iter == '0) begin
            reads_cfg_s = LOG_MAX_READS_PER_ITER'(1);
        end else begin
            reads_cfg_s = num_reads_per_iter;
        end
        for (int k = 0; k < GROUP_SIZE; k++) begin
            sum_s[k] = acc_r[k] + sext(data_in[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Control FSM, accumulators and registered outputs. Configure wins over
    // any simultaneous accept or output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            iters_r    <= LOG_MAX_ITERS'(1);
            reads_r    <= LOG_MAX_READS_PER_ITER'(1);
            iter_cnt_r <= '0;
            read_cnt_r <= '0;
            for (int k = 0; k < GROUP_SIZE; k++) begin
                acc_r[k] <= '0;
            end
            data_out   <= '0;
            valid_out  <= 1'b0;
            avail_out  <= 1'b0;
            done       <= 1'b0;
        end else if (configure) begin
            state_r    <= RUN;
            iters_r    <= iters_cfg_s;
            reads_r    <= reads_cfg_s;
            iter_cnt_r <= '0;
            read_cnt_r <= '0;
            for (int k = 0; k < GROUP_SIZE; k++) begin
                acc_r[k] <= '0;
            end
            valid_out  <= 1'b0;
            avail_out  <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    avail_out <= 1'b0;
                end
                RUN: begin
                    if (accept_s) begin
                        if (last_read_s) begin
                            // Final word of the iteration goes straight into the output.
                            for (int k = 0; k < GROUP_SIZE; k++) begin
                                data_out[k*ACC_WIDTH +: ACC_WIDTH] <= sum_s[k];
                                acc_r[k] <= '0;
                            end
                            read_cnt_r <= '0;
                            valid_out  <= 1'b1;
                            avail_out  <= 1'b0;
                            state_r    <= OUT;
                        end else begin
                            for (int k = 0; k < GROUP_SIZE; k++) begin
                                acc_r[k] <= sum_s[k];
                            end
                            read_cnt_r <= read_cnt_r + LOG_MAX_READS_PER_ITER'(1);
                        end
                    end
                end
                OUT: begin
                    if (avail_in) begin
                        valid_out <= 1'b0;
                        if (last_iter_s) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            iter_cnt_r <= iter_cnt_r + LOG_MAX_ITERS'(1);
                            avail_out  <= 1'b1;
                            state_r    <= RUN;
                        end
                    end
                end
                DONE: begin
                    avail_out <= 1'b0;
                    valid_out <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    avail_out <= 1'b0;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_group_accumulator.sv
// Self-checking bench for group_accumulator. A reference model records every
// accepted word and, once enough words for one iteration have arrived, pushes
// the lane sums into a queue. A separate monitor compares each output
// handshake against the head of that queue.
module tb_group_accumulator;
    localparam int DW = 16;
    localparam int GS = 4;
    localparam int AW = 32;
    localparam int LI = 16;
    localparam int LR = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            configure = 1'b0;
    logic [LI-1:0]   num_iters = '0;
    logic [LR-1:0]   num_reads_per_iter = '0;
    logic [GS*DW-1:0] data_in = '0;
    logic            valid_in = 1'b0;
    logic            avail_out;
    logic [GS*AW-1:0] data_out;
    logic            valid_out;
    logic            avail_in = 1'b0;
    logic            done;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;
    int outputs  = 0;

    logic [GS*AW-1:0] exp_q[$];
    logic [GS*DW-1:0] words[$];
    int               m_reads = 1;

    group_accumulator #(
        .DATA_WIDTH(DW), .GROUP_SIZE(GS), .ACC_WIDTH(AW),
        .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)
    ) dut (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads_per_iter), .data_in(data_in), .valid_in(valid_in),
        .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
        .avail_in(avail_in), .done(done)
    );

    always #5 clk = ~clk;

    // Plain signed arithmetic over the words collected for one iteration.
    function automatic logic [GS*AW-1:0] sum_words();
        logic [GS*AW-1:0] r;
        logic [DW-1:0]    lane;
        longint           s;
        r = '0;
        for (int k = 0; k < GS; k++) begin
            s = 0;
            foreach (words[i]) begin
                lane = words[i][k*DW +: DW];
                s += longint'($signed(lane));
            end
            r[k*AW +: AW] = s[AW-1:0];
        end
        return r;
    endfunction

    // Reference model: watches the input handshake.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            words.delete();
        end else if (configure) begin
            exp_q.delete();
            words.delete();
            m_reads = (num_reads_per_iter == '0) ? 1 : int'(num_reads_per_iter);
        end else if (valid_in && avail_out) begin
            accepts++;
            words.push_back(data_in);
            if (words.size() == m_reads) begin
                exp_q.push_back(sum_words());
                words.delete();
            end
        end
    end

    // Monitor: watches the output handshake and compares against the queue.
    always @(negedge clk) begin
        logic [GS*AW-1:0] e;
        if (rst && valid_out) begin
            checks++;
            if (avail_out) begin
                failures++;
                $display("FAIL avail_excl avail_out=1 while valid_out=1 required=0");
            end
        end
        if (rst && !configure && valid_out && avail_in) begin
            checks++;
            outputs++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h required=none", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    failures++;
                    $display("FAIL sum got=%h required=%h", data_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_config(input int it, input int rd);
        num_iters          = LI'(it);
        num_reads_per_iter = LR'(rd);
        configure          = 1'b1;
        tick();
        configure          = 1'b0;
    endtask

    // Present one word and hold it until the block takes it.
    task automatic send(input logic [GS*DW-1:0] w);
        int n;
        data_in  = w;
        valid_in = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (avail_out) break;
        end
        if (n == 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=no_accept required=accept");
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        for (n = 0; n < 100 && !valid_out; n++) tick();
        check("valid_wait", 128'(valid_out), 128'(1));
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 500 && !done; n++) tick();
        check("done", 128'(done), 128'(1));
        check("queue_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic [GS*AW-1:0] held;
        int a0;
        int o0;
        int it;
        int rd;
        int cfg_at;
        int cyc;

        // Reset values.
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_avail_out", 128'(avail_out), 128'(0));
        check("rst_valid_out", 128'(valid_out), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_data_out", 128'(data_out), 128'(0));
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Test 1: two iterations of four reads, expected lane sums 10 then 26.
        avail_in = 1'b1;
        a0 = accepts;
        o0 = outputs;
        do_config(2, 4);
        for (int v = 1; v <= 8; v++) send({4{16'(v)}});
        wait_done();
        check("t1_accepts", 128'(accepts - a0), 128'(8));
        check("t1_outputs", 128'(outputs - o0), 128'(2));
        tick();
        check("t1_done_avail", 128'(avail_out), 128'(0));

        // Test 2: backpressure holds the output.
        avail_in = 1'b0;
        do_config(1, 2);
        send({4{16'h0003}});
        send({4{16'h0004}});
        wait_valid();
        held     = data_out;
        a0       = accepts;
        data_in  = {4{16'h1111}};
        valid_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_data_stable", 128'(data_out), 128'(held));
            check("bp_valid", 128'(valid_out), 128'(1));
            check("bp_avail_out", 128'(avail_out), 128'(0));
        end
        check("bp_accepts", 128'(accepts - a0), 128'(0));
        valid_in = 1'b0;
        avail_in = 1'b1;
        wait_done();

        // Test 3: sign extension and wrap.
        avail_in = 1'b0;
        do_config(1, 4);
        for (int c = 0; c < 4; c++) send({16'($urandom), 16'($urandom), 16'h7FFF, 16'hFFFF});
        wait_valid();
        check("sign_lane0", 128'(data_out[31:0]), 128'(32'hFFFF_FFFC));
        check("sign_lane1", 128'(data_out[63:32]), 128'(32'h0001_FFFC));
        avail_in = 1'b1;
        wait_done();

        // Test 4: reads=0 acts as one read per output.
        do_config(3, 0);
        send({4{16'h0007}});
        send({4{16'hFFFE}});
        send({4{16'h8000}});
        wait_done();

        // Test 5: reset mid-iteration, then no stale sum.
        do_config(1, 4);
        send({4{16'h0009}});
        send({4{16'h0009}});
        rst = 1'b0;
        #1;
        check("r5_avail_out", 128'(avail_out), 128'(0));
        check("r5_valid_out", 128'(valid_out), 128'(0));
        check("r5_done", 128'(done), 128'(0));
        check("r5_data_out", 128'(data_out), 128'(0));
        tick();
        rst = 1'b1;
        tick();
        avail_in = 1'b0;
        do_config(1, 4);
        for (int c = 0; c < 4; c++) send({4{16'h0001}});
        wait_valid();
        check("r5_sum4", 128'(data_out), 128'({4{32'd4}}));
        avail_in = 1'b1;
        wait_done();

        // Test 6: random gaps, random backpressure, configure mid-run.
        for (int round = 0; round < 4; round++) begin
            it     = $urandom_range(1, 3);
            rd     = $urandom_range(0, 5);
            cfg_at = $urandom_range(2, 8);
            do_config(it, rd);
            for (cyc = 0; cyc < 3000 && !done; cyc++) begin
                valid_in  = 1'($urandom_range(0, 1));
                data_in   = {$urandom, $urandom};
                avail_in  = ($urandom_range(0, 3) != 0);
                configure = (cyc == cfg_at);
                tick();
            end
            configure = 1'b0;
            valid_in  = 1'b0;
            avail_in  = 1'b1;
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
